seq_arith_unit: RTL and testbench

Parametrised, clocked successor to the team's combinational 8-bit add/sub/mul/div block. Takes two unsigned WIDTH-bit operands and an opcode under a start/done handshake. ADD and SUB finish in one cycle. MUL runs iterative shift-add and DIV runs iterative restoring division, each over WIDTH cycles. Returns a double-width result plus a divide-by-zero flag, and sits between a controller FSM and the datapath register file.

---
 rtl/seq_arith_pkg.sv | 15 +
 rtl/seq_arith_iter_core.sv | 70 +++++++
 rtl/seq_arith_unit.sv | 127 ++++++++++++
 tb/tb_seq_arith_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_arith_pkg.sv
// Shared opcodes and FSM state encoding for the sequential arithmetic unit.
package seq_arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_arith_iter_core.sv
// One shift-add multiply or restoring-divide step per enable, sharing a single
// WIDTH+2-bit adder. Exposes the next-step values so the caller can capture the final step.
module seq_arith_iter_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] b_r;
  logic             div_r;
  logic [WIDTH:0]   lhs_s;
  logic [WIDTH:0]   addend_s;
  logic [WIDTH+1:0] sum_s;

  // Shared adder: MUL adds B to the partial product; DIV subtracts B from the shifted remainder.
  always_comb begin
    lhs_s    = div_r ? {hi_r, lo_r[WIDTH-1]} : {1'b0, hi_r};
    addend_s = div_r ? ~{1'b0, b_r} : {1'b0, b_r};
    sum_s    = {1'b0, lhs_s} + {1'b0, addend_s} + {{(WIDTH+1){1'b0}}, div_r};
  end

  // Next-step selection; sum_s[WIDTH+1] is the "no borrow" bit of the divide trial subtraction.
  always_comb begin
    hi_nxt = hi_r;
    lo_nxt = lo_r;
    if (div_r) begin
      if (sum_s[WIDTH+1]) begin
        hi_nxt = sum_s[WIDTH-1:0];
      end else begin
        hi_nxt = lhs_s[WIDTH-1:0];
      end
      lo_nxt = {lo_r[WIDTH-2:0], sum_s[WIDTH+1]};
    end else begin
      if (lo_r[0]) begin
        {hi_nxt, lo_nxt} = {sum_s[WIDTH:0], lo_r[WIDTH-1:1]};
      end else begin
        {hi_nxt, lo_nxt} = {1'b0, hi_r, lo_r[WIDTH-1:1]};
      end
    end
  end

  // Working registers: load seeds the operands, en advances one iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r  <= {WIDTH{1'b0}};
      lo_r  <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      div_r <= 1'b0;
    end else if (load) begin
      hi_r  <= {WIDTH{1'b0}};
      lo_r  <= a;
      b_r   <= b;
      div_r <= is_div;
    end else if (en) begin
      hi_r  <= hi_nxt;
      lo_r  <= lo_nxt;
    end
  end

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential add/sub/mul/div unit with a start/done handshake; MUL and DIV
// iterate over WIDTH cycles in seq_arith_iter_core, results are registered on entry to DONE.
module seq_arith_unit
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_value_a,
  input  logic [WIDTH-1:0] i_value_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result_lo,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             dz_pend_r;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic             core_load_s;
  logic             core_en_s;
  logic             core_div_s;
  logic [WIDTH-1:0] core_hi_s;
  logic [WIDTH-1:0] core_lo_s;

  // Single-cycle ADD/SUB results and iteration-core controls.
  always_comb begin
    add_s       = {1'b0, i_value_a} + {1'b0, i_value_b};
    sub_s       = {1'b0, i_value_a} - {1'b0, i_value_b};
    core_load_s = (state_r == ST_IDLE) && i_start && i_op[1];
    core_en_s   = (state_r == ST_RUN);
    core_div_s  = (i_op == OP_DIV);
  end

  seq_arith_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (core_load_s),
    .en     (core_en_s),
    .is_div (core_div_s),
    .a      (i_value_a),
    .b      (i_value_b),
    .hi_nxt (core_hi_s),
    .lo_nxt (core_lo_s)
  );

  // FSM, iteration counter, handshake and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CW{1'b0}};
      dz_pend_r     <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_result_lo   <= {WIDTH{1'b0}};
      o_result_hi   <= {WIDTH{1'b0}};
      o_div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            o_busy <= 1'b1;
            case (i_op)
              OP_ADD: begin
                state_r       <= ST_DONE;
                o_done        <= 1'b1;
                o_result_lo   <= add_s[WIDTH-1:0];
                o_result_hi   <= {{(WIDTH-1){1'b0}}, add_s[WIDTH]};
                o_div_by_zero <= 1'b0;
              end
              OP_SUB: begin
                state_r       <= ST_DONE;
                o_done        <= 1'b1;
                o_result_lo   <= sub_s[WIDTH-1:0];
                o_result_hi   <= {{(WIDTH-1){1'b0}}, sub_s[WIDTH]};
                o_div_by_zero <= 1'b0;
              end
              OP_MUL, OP_DIV: begin
                state_r   <= ST_RUN;
                cnt_r     <= CW'(WIDTH);
                dz_pend_r <= (i_op == OP_DIV) && (i_value_b == {WIDTH{1'b0}});
              end
              default: begin
                state_r <= ST_IDLE;
                o_busy  <= 1'b0;
              end
            endcase
          end else begin
            o_busy <= 1'b0;
          end
        end
        ST_RUN: begin
          // The last iteration lands directly in the result registers.
          if (cnt_r == CW'(1)) begin
            state_r       <= ST_DONE;
            o_done        <= 1'b1;
            o_result_lo   <= core_lo_s;
            o_result_hi   <= core_hi_s;
            o_div_by_zero <= dz_pend_r;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Self-checking bench: directed and randomized ops on 8- and 16-bit instances
// compared against an arithmetic reference model.
module tb_seq_arith_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, busy8, done8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, lo8, hi8;
  logic        start16, busy16, done16, dz16;
  logic [1:0]  op16;
  logic [15:0] a16, b16, lo16, hi16;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  seq_arith_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .i_start(start8), .i_op(op8),
    .i_value_a(a8), .i_value_b(b8), .o_busy(busy8), .o_done(done8),
    .o_result_lo(lo8), .o_result_hi(hi8), .o_div_by_zero(dz8)
  );

  seq_arith_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .i_start(start16), .i_op(op16),
    .i_value_a(a16), .i_value_b(b16), .o_busy(busy16), .o_done(done16),
    .o_result_lo(lo16), .o_result_hi(hi16), .o_div_by_zero(dz16)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input int w, input logic [1:0] op, input longint a, input longint b,
                       output longint lo, output longint hi, output longint dz);
    longint m;
    m  = longint'(1) << w;
    dz = 0;
    case (op)
      2'd0: begin lo = (a + b) % m; hi = (a + b) / m; end
      2'd1: begin lo = (a - b + m) % m; hi = (a < b) ? 1 : 0; end
      2'd2: begin lo = (a * b) % m; hi = (a * b) / m; end
      default: begin
        if (b == 0) begin lo = m - 1; hi = a; dz = 1; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  // One op on the 8-bit unit; with disturb, garbage starts/operands are driven while busy.
  task automatic run8(input string tag, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input bit disturb);
    int lat, busy_cnt, ndone;
    longint elo, ehi, edz;
    model(8, op, a, b, elo, ehi, edz);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    tick;
    start8 = 1'b0;
    lat = 1; busy_cnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      if (disturb) begin
        start8 = (lat == 3) || ($urandom_range(0, 1) == 1);
        op8 = (lat == 3) ? 2'b00 : 2'($urandom_range(0, 3));
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
      tick;
      start8 = 1'b0;
      lat++;
    end
    check({tag, " latency"}, lat, (op < 2'd2) ? 1 : 9);
    check({tag, " busy cycles"}, busy_cnt + int'(busy8), lat);
    check({tag, " lo"}, lo8, elo);
    check({tag, " hi"}, hi8, ehi);
    check({tag, " dz"}, dz8, edz);
    if (disturb) begin
      start8 = 1'b1; op8 = 2'b00; a8 = 8'($urandom); b8 = 8'($urandom);
    end
    ndone = 0;
    tick;
    start8 = 1'b0;
    if (disturb) begin
      repeat (3) begin
        ndone += int'(done8) + int'(busy8);
        tick;
      end
      check({tag, " extra done/busy"}, ndone, 0);
    end
    check({tag, " idle after done"}, {busy8, done8}, 0);
    check({tag, " lo held"}, lo8, elo);
  endtask

  // Start an op, assert reset after k cycles, expect immediate zeros and no o_done.
  task automatic abort8(input string tag, input logic [1:0] op, input int k);
    int ndone;
    start8 = 1'b1; op8 = op; a8 = 8'($urandom); b8 = 8'($urandom);
    tick;
    start8 = 1'b0;
    repeat (k - 1) tick;
    reset = 1'b1;
    #1;
    check({tag, " outputs zero"}, {busy8, done8, lo8, hi8, dz8}, 0);
    tick;
    reset = 1'b0;
    ndone = 0;
    repeat (12) begin
      ndone += int'(done8) + int'(busy8);
      tick;
    end
    check({tag, " no done after abort"}, ndone, 0);
  endtask

  task automatic run16(input string tag, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    int lat;
    longint elo, ehi, edz;
    model(16, op, a, b, elo, ehi, edz);
    start16 = 1'b1; op16 = op; a16 = a; b16 = b;
    tick;
    start16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 60) begin
      tick;
      lat++;
    end
    check({tag, " latency"}, lat, (op < 2'd2) ? 1 : 17);
    check({tag, " lo"}, lo16, elo);
    check({tag, " hi"}, hi16, ehi);
    check({tag, " dz"}, dz16, edz);
    tick;
  endtask

  initial begin
    logic [1:0] op;
    logic [7:0] a, b;
    reset = 1'b1;
    start8 = 1'b0; op8 = 2'b00; a8 = 8'd0; b8 = 8'd0;
    start16 = 1'b0; op16 = 2'b00; a16 = 16'd0; b16 = 16'd0;
    tick; tick;
    check("reset dut8", {busy8, done8, lo8, hi8, dz8}, 0);
    check("reset dut16", {busy16, done16, lo16, hi16, dz16}, 0);
    reset = 1'b0;
    tick;

    run8("add 20+10", 2'b00, 8'd20, 8'd10, 1'b0);
    run8("sub 10-20", 2'b01, 8'd10, 8'd20, 1'b0);
    run8("mul 20*10", 2'b10, 8'd20, 8'd10, 1'b0);
    run8("mul 255*255", 2'b10, 8'd255, 8'd255, 1'b0);
    run8("div 200/7", 2'b11, 8'd200, 8'd7, 1'b0);
    run8("div 5/0", 2'b11, 8'd5, 8'd0, 1'b0);
    run8("handshake mul", 2'b10, 8'd20, 8'd10, 1'b1);
    run8("reaccept add", 2'b00, 8'd1, 8'd2, 1'b0);
    abort8("reset mid div", 2'b11, 4);
    run8("add after reset", 2'b00, 8'd1, 8'd1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) tick;
      if ($urandom_range(0, 39) == 0) begin
        abort8("rnd abort", 2'($urandom_range(2, 3)), int'($urandom_range(1, 8)));
      end else begin
        op = 2'($urandom_range(0, 3));
        a = 8'($urandom);
        b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        run8("rnd", op, a, b, ($urandom_range(0, 3) == 0));
      end
    end

    run16("w16 mul max", 2'b10, 16'hFFFF, 16'hFFFF);
    for (int j = 0; j < 20; j++) begin
      run16("w16 rnd", 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom_range(0, 300)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
